// File: rtl/gpu_command_queue_if.sv
// Bus between the CPU-side instruction producer and the blanking-gated command queue.
// The master drives commands and display timing; the slave is the queue itself.
interface gpu_command_queue_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [34:0]   CmdData;
    logic          CmdValid;
    logic          CmdReady;
    logic          Flush;
    logic          Blanking;
    logic [34:0]   Instruction;
    logic [CW-1:0] Count;
    logic          Busy;

    modport master (
        output CmdData, CmdValid, Flush, Blanking,
        input  CmdReady, Instruction, Count, Busy
    );

    modport slave (
        input  CmdData, CmdValid, Flush, Blanking,
        output CmdReady, Instruction, Count, Busy
    );
endinterface

// File: rtl/gpu_command_queue.sv
// Buffers sprite instructions and replays them onto the GPU Instruction bus only during
// display blanking, at most BURST_MAX per window; NOP (all zeros) is driven otherwise.
module gpu_command_queue #(
    parameter int DEPTH     = 16,
    parameter int BURST_MAX = 64
) (
    input logic                Clk,
    input logic                Rst_n,
    gpu_command_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [7:0]    BURST_LIM  = 8'(BURST_MAX);

    typedef enum logic [1:0] {
        WAIT_BLANK  = 2'd0,
        ISSUE       = 2'd1,
        WAIT_ACTIVE = 2'd2
    } state_t;

    logic [34:0]   mem_q [DEPTH];
    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;
    logic [7:0]    burst_q, burst_d;
    logic [34:0]   instr_q, instr_d;
    logic          push;
    logic          pop;

    // Ready looks only at the registered count, so a full queue never accepts on the cycle it pops.
    assign bus.CmdReady    = Rst_n & ~bus.Flush & (count_q != FULL_COUNT);
    assign push            = bus.CmdValid & bus.CmdReady;
    assign bus.Instruction = instr_q;
    assign bus.Count       = count_q;
    assign bus.Busy        = (count_q != '0) | (state_q == ISSUE);

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        instr_d = '0;
        pop     = 1'b0;
        case (state_q)
            WAIT_BLANK: begin
                if (bus.Blanking) begin
                    burst_d = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!bus.Blanking) begin
                    state_d = WAIT_BLANK;
                end else if ((count_q != '0) && (burst_q < BURST_LIM)) begin
                    instr_d = mem_q[rd_ptr_q[AW-1:0]];
                    pop     = 1'b1;
                    burst_d = burst_q + 8'd1;
                end else if (burst_q == BURST_LIM) begin
                    state_d = WAIT_ACTIVE;
                end
            end
            WAIT_ACTIVE: begin
                if (!bus.Blanking) begin
                    state_d = WAIT_BLANK;
                end
            end
            default: state_d = WAIT_BLANK;
        endcase
        // Flush wins over everything, including a pop the window would otherwise take.
        if (bus.Flush) begin
            state_d = WAIT_BLANK;
            burst_d = '0;
            instr_d = '0;
            pop     = 1'b0;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + CW'(push);
        rd_ptr_d = rd_ptr_q + CW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        if (bus.Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= WAIT_BLANK;
            burst_q  <= '0;
            instr_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            burst_q  <= burst_d;
            instr_q  <= instr_d;
        end
    end

    // Storage carries no reset; validity is tracked entirely by the pointers and count.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus.CmdData;
        end
    end
endmodule
